pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Central hazard/pipeline-control unit; drives the stall/flush pairs consumed by the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
//  Detects load-use hazards, branch/jump redirects resolved in MEM, and multi-cycle data-memory waits.
//  Pipeline registers give !stall (load) precedence over flush, so every flush is issued together with stall=1 for that register.
// PARAMETERS
//  MEM_TIMEOUT  15  max MEMWAIT cycles before abort (1..255)
//  CNT_W        16  width of saturating stall-cycle counter
// PORTS
//  clk           in   1      pipeline clock
//  rst           in   1      synchronous, active-high reset
//  id_rs,id_rt   in   5      source regs of instruction in ID
//  id_uses_rt    in   1      ID instruction reads rt
//  ex_MemRead    in   1      ID/EX holds a load
//  ex_rt         in   5      load destination in ID/EX
//  mem_Branch    in   1      EX/MEM Branch_out
//  mem_Zero      in   1      EX/MEM Zero_out
//  mem_Jump      in   1      EX/MEM Jump_out
//  mem_req       in   1      EX/MEM MemRead_out|MemWr_out
//  mem_ready     in   1      data memory completes this cycle
//  pc_stall      out  1      hold PC
//  pc_redirect   out  1      PC takes branch/jump target
//  {ifid,idex,exmem,memwb}_stall  out 1 each  hold register
//  {ifid,idex,exmem,memwb}_flush  out 1 each  clear register (only with matching stall=1)
//  mem_err       out  1      sticky: memory timeout occurred
//  stall_cnt     out  CNT_W  saturating count of cycles with pc_stall=1
// BEHAVIOUR
//  State reg (RUN, MEMWAIT), wait counter, mem_err, stall_cnt registered; control outputs combinational from state+inputs (same-cycle effect).
//  rst=1: all *_stall=1, all *_flush=1, pc_stall=1, pc_redirect=0; next state RUN, wait cnt=0, mem_err=0, stall_cnt=0.
//  Priority in RUN (first match wins, others masked):
//   1. mem_req & !mem_ready: pc/ifid/idex/exmem stall=1; memwb_stall=memwb_flush=1 (bubble to WB); -> MEMWAIT, wait cnt=1.
//   2. taken = (mem_Branch&mem_Zero)|mem_Jump: pc_redirect=1; ifid,idex,exmem stall=1 and flush=1; memwb loads normally.
//   3. load-use = ex_MemRead & ex_rt!=0 & (ex_rt==id_rs | id_uses_rt&ex_rt==id_rt): pc_stall=ifid_stall=1; idex_stall=idex_flush=1.
//   4. none: all outputs 0.
//  MEMWAIT: outputs as case 1.
//   mem_ready=1: outputs as case 1 this cycle (memwb bubble), -> RUN; branch in EX/MEM is evaluated next cycle in RUN.
//   else cnt==MEM_TIMEOUT: mem_err<=1, -> RUN (EX/MEM access abandoned, not retried); else cnt++.
//  mem_req & mem_ready in RUN: zero-wait access, no stall.
//  stall_cnt increments every non-reset cycle with pc_stall=1 and saturates at all-ones.
//  mem_err clears only on rst.
// STRUCTURE
//  pipe_ctrl_pkg: state enum {RUN,MEMWAIT}, REG_ZERO=5'd0.
//  Sub-module hazard_lu_detect: combinational load-use compare.
//  Top holds FSM, counters, output decode.
// TESTING
//  Load-use: ex_MemRead=1, ex_rt=8, id_rs=8 -> 1 cycle pc_stall=ifid_stall=idex_flush=idex_stall=1; ex_rt=0 -> no stall.
//  Branch: mem_Branch=1, mem_Zero=1 (with load-use active) -> pc_redirect=1, ifid/idex/exmem flush+stall=1, no pc_stall.
//  Mem wait: mem_req=1, mem_ready low 3 cycles then high -> 4 cycles full stall + memwb_flush, stall_cnt=4, back in RUN.
//  Timeout: mem_ready held 0 -> mem_err=1 after MEM_TIMEOUT cycles in MEMWAIT, state RUN, stalls drop.
//  Reset mid-MEMWAIT: rst=1 -> all stall/flush=1 that cycle; next cycle RUN, mem_err=0, stall_cnt=0.
//  Saturation: CNT_W=4, 20 stall cycles -> stall_cnt=15.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/control unit.
//   state_t  : controller FSM states (RUN, MEMWAIT)
//   ctrl_t   : packed bundle of the PC and pipeline-register control lines
//   CTRL_*   : the fixed control patterns the controller can emit
//   REG_ZERO : architectural zero register, never a real hazard source
package pipe_ctrl_pkg;

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MEMWAIT = 1'b1
    } state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam int         WAIT_W   = 8;

    // stall/flush bit order, MSB to LSB: ifid, idex, exmem, memwb
    typedef struct packed {
        logic       pc_stall;
        logic       pc_redirect;
        logic [3:0] stall;
        logic [3:0] flush;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE  = '{1'b0, 1'b0, 4'b0000, 4'b0000};
    localparam ctrl_t CTRL_RESET = '{1'b1, 1'b0, 4'b1111, 4'b1111};
    // Memory wait: freeze everything up to EX/MEM, inject a bubble into MEM/WB.
    localparam ctrl_t CTRL_MEMW  = '{1'b1, 1'b0, 4'b1111, 4'b0001};
    // Redirect: squash the three younger stages; each flush carries its stall.
    localparam ctrl_t CTRL_TAKEN = '{1'b0, 1'b1, 4'b1110, 4'b1110};
    // Load-use: hold PC and IF/ID, bubble into ID/EX.
    localparam ctrl_t CTRL_LU    = '{1'b1, 1'b0, 4'b1100, 4'b0100};

    // True when a branch resolved in MEM is taken or a jump sits in MEM.
    function automatic logic redirect_taken(input logic branch,
                                            input logic zero,
                                            input logic jump);
        return (branch & zero) | jump;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle of hazard-detection inputs and pipeline-control outputs.
//   master : pipeline datapath side (drives hazard info, receives controls)
//   slave  : hazard controller side (receives hazard info, drives controls)
interface pipe_hazard_ctrl_if;

    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rt;
    logic       ex_MemRead;
    logic [4:0] ex_rt;
    logic       mem_Branch;
    logic       mem_Zero;
    logic       mem_Jump;
    logic       mem_req;
    logic       mem_ready;

    logic       pc_stall;
    logic       pc_redirect;
    logic       ifid_stall;
    logic       idex_stall;
    logic       exmem_stall;
    logic       memwb_stall;
    logic       ifid_flush;
    logic       idex_flush;
    logic       exmem_flush;
    logic       memwb_flush;

    modport master (
        output id_rs, id_rt, id_uses_rt, ex_MemRead, ex_rt,
               mem_Branch, mem_Zero, mem_Jump, mem_req, mem_ready,
        input  pc_stall, pc_redirect,
               ifid_stall, idex_stall, exmem_stall, memwb_stall,
               ifid_flush, idex_flush, exmem_flush, memwb_flush
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_MemRead, ex_rt,
               mem_Branch, mem_Zero, mem_Jump, mem_req, mem_ready,
        output pc_stall, pc_redirect,
               ifid_stall, idex_stall, exmem_stall, memwb_stall,
               ifid_flush, idex_flush, exmem_flush, memwb_flush
    );

endinterface

// File: rtl/hazard_lu_detect.sv
// Combinational load-use hazard compare.
//   id_rs, id_rt, id_uses_rt : source operands of the instruction in ID
//   ex_mem_read, ex_rt       : load in ID/EX and its destination register
//   hazard                   : ID instruction needs the load result next cycle
module hazard_lu_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rt,
    output logic       hazard
);

    logic rs_match_s;
    logic rt_match_s;

    assign rs_match_s = (ex_rt == id_rs);
    assign rt_match_s = id_uses_rt & (ex_rt == id_rt);

    // A load into the zero register never produces a value worth waiting for.
    assign hazard = ex_mem_read & (ex_rt != REG_ZERO) & (rs_match_s | rt_match_s);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central hazard / pipeline-control unit.
//   clk, rst   : pipeline clock, synchronous active-high reset
//   bus        : hazard inputs and PC / pipeline-register stall+flush outputs
//   mem_err    : sticky flag, a data-memory access exceeded MEM_TIMEOUT
//   stall_cnt  : saturating count of cycles with pc_stall asserted
// Control outputs decode combinationally from the FSM state and the current
// inputs so a hazard takes effect in the same cycle it is seen.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    pipe_hazard_ctrl_if.slave bus,
    output logic              mem_err,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_ONE   = {{(WAIT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t              state_r;
    logic [WAIT_W-1:0]   wait_cnt_r;
    logic                mem_err_r;
    logic [CNT_W-1:0]    stall_cnt_r;

    logic                lu_hazard_s;
    logic                taken_s;
    logic                mem_wait_s;
    ctrl_t               ctrl_s;

    hazard_lu_detect u_lu (
        .id_rs       (bus.id_rs),
        .id_rt       (bus.id_rt),
        .id_uses_rt  (bus.id_uses_rt),
        .ex_mem_read (bus.ex_MemRead),
        .ex_rt       (bus.ex_rt),
        .hazard      (lu_hazard_s)
    );

    assign taken_s    = redirect_taken(bus.mem_Branch, bus.mem_Zero, bus.mem_Jump);
    // A request completing in the same cycle is a zero-wait access.
    assign mem_wait_s = bus.mem_req & ~bus.mem_ready;

    // Output decode: reset pattern, then memory wait > redirect > load-use.
    always_comb begin
        ctrl_s = CTRL_NONE;
        if (rst) begin
            ctrl_s = CTRL_RESET;
        end else begin
            case (state_r)
                RUN: begin
                    if (mem_wait_s) begin
                        ctrl_s = CTRL_MEMW;
                    end else if (taken_s) begin
                        ctrl_s = CTRL_TAKEN;
                    end else if (lu_hazard_s) begin
                        ctrl_s = CTRL_LU;
                    end else begin
                        ctrl_s = CTRL_NONE;
                    end
                end
                // Includes the completion and timeout cycles; a branch held in
                // EX/MEM is only acted on once back in RUN.
                MEMWAIT: ctrl_s = CTRL_MEMW;
                default: ctrl_s = CTRL_NONE;
            endcase
        end
    end

    // FSM, memory wait counter, sticky error flag and stall statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= RUN;
            wait_cnt_r  <= '0;
            mem_err_r   <= 1'b0;
            stall_cnt_r <= '0;
        end else begin
            if (ctrl_s.pc_stall && (stall_cnt_r != {CNT_W{1'b1}})) begin
                stall_cnt_r <= stall_cnt_r + CNT_ONE;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end

            case (state_r)
                RUN: begin
                    if (mem_wait_s) begin
                        state_r    <= MEMWAIT;
                        wait_cnt_r <= WAIT_ONE;
                    end else begin
                        state_r    <= RUN;
                        wait_cnt_r <= '0;
                    end
                end
                MEMWAIT: begin
                    if (bus.mem_ready) begin
                        state_r    <= RUN;
                        wait_cnt_r <= '0;
                    end else if (wait_cnt_r == WAIT_LIMIT) begin
                        // Access is abandoned, not retried; pipeline resumes.
                        state_r    <= RUN;
                        wait_cnt_r <= '0;
                        mem_err_r  <= 1'b1;
                    end else begin
                        state_r    <= MEMWAIT;
                        wait_cnt_r <= wait_cnt_r + WAIT_ONE;
                    end
                end
                default: begin
                    state_r    <= RUN;
                    wait_cnt_r <= '0;
                end
            endcase
        end
    end

    assign bus.pc_stall    = ctrl_s.pc_stall;
    assign bus.pc_redirect = ctrl_s.pc_redirect;
    assign bus.ifid_stall  = ctrl_s.stall[3];
    assign bus.idex_stall  = ctrl_s.stall[2];
    assign bus.exmem_stall = ctrl_s.stall[1];
    assign bus.memwb_stall = ctrl_s.stall[0];
    assign bus.ifid_flush  = ctrl_s.flush[3];
    assign bus.idex_flush  = ctrl_s.flush[2];
    assign bus.exmem_flush = ctrl_s.flush[1];
    assign bus.memwb_flush = ctrl_s.flush[0];

    assign mem_err   = mem_err_r;
    assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: a vector table for the RUN-state
// priority decode, hand sequences for memory wait, timeout, reset during a
// wait, and a narrow-counter instance for saturation.
module tb_pipe_hazard_ctrl;

    // Output word order: pc_stall, pc_redirect, stall{ifid,idex,exmem,memwb},
    // flush{ifid,idex,exmem,memwb}
    localparam logic [9:0] O_NONE  = 10'b0_0_0000_0000;
    localparam logic [9:0] O_RESET = 10'b1_0_1111_1111;
    localparam logic [9:0] O_MEMW  = 10'b1_0_1111_0001;
    localparam logic [9:0] O_TAKEN = 10'b0_1_1110_1110;
    localparam logic [9:0] O_LU    = 10'b1_0_1100_0100;

    typedef struct {
        string      name;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       use_rt;
        logic       mread;
        logic [4:0] ert;
        logic       br;
        logic       zero;
        logic       jmp;
        logic       req;
        logic       rdy;
        logic [9:0] exp;
    } vec_t;

    logic clk;
    logic rst;
    logic        mem_err;
    logic [15:0] stall_cnt;
    logic        mem_err2;
    logic [3:0]  stall_cnt2;

    int n_vec;
    int n_err;
    int exp_cnt;

    pipe_hazard_ctrl_if bus ();
    pipe_hazard_ctrl_if bus2 ();

    pipe_hazard_ctrl #(.MEM_TIMEOUT(15), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .bus(bus), .mem_err(mem_err), .stall_cnt(stall_cnt)
    );

    pipe_hazard_ctrl #(.MEM_TIMEOUT(15), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .bus(bus2), .mem_err(mem_err2), .stall_cnt(stall_cnt2)
    );

    logic [9:0] out_s;
    assign out_s = {bus.pc_stall, bus.pc_redirect,
                    bus.ifid_stall, bus.idex_stall, bus.exmem_stall, bus.memwb_stall,
                    bus.ifid_flush, bus.idex_flush, bus.exmem_flush, bus.memwb_flush};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic set_in(input vec_t v);
        bus.id_rs      = v.rs;
        bus.id_rt      = v.rt;
        bus.id_uses_rt = v.use_rt;
        bus.ex_MemRead = v.mread;
        bus.ex_rt      = v.ert;
        bus.mem_Branch = v.br;
        bus.mem_Zero   = v.zero;
        bus.mem_Jump   = v.jmp;
        bus.mem_req    = v.req;
        bus.mem_ready  = v.rdy;
    endtask

    task automatic clear_in();
        vec_t z;
        z = '{"", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0};
        set_in(z);
    endtask

    // Inputs are already driven at the negedge; check, then advance one cycle.
    task automatic cycle(input string name, input logic [9:0] exp);
        #1;
        chk(name, {22'd0, out_s}, {22'd0, exp});
        if (!rst && exp[9]) exp_cnt++;
        @(posedge clk);
        @(negedge clk);
    endtask

    vec_t vecs [14];

    initial begin
        n_vec   = 0;
        n_err   = 0;
        exp_cnt = 0;

        //          name           rs     rt     use   mrd   ert    br    z     j     req   rdy   exp
        vecs[0]  = '{"idle",       5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE};
        vecs[1]  = '{"lu_rs",      5'd8,  5'd0,  1'b0, 1'b1, 5'd8,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_LU};
        vecs[2]  = '{"lu_r0",      5'd0,  5'd0,  1'b1, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE};
        vecs[3]  = '{"lu_rt",      5'd3,  5'd8,  1'b1, 1'b1, 5'd8,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_LU};
        vecs[4]  = '{"rt_unused",  5'd3,  5'd8,  1'b0, 1'b1, 5'd8,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE};
        vecs[5]  = '{"no_load",    5'd8,  5'd8,  1'b1, 1'b0, 5'd8,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE};
        vecs[6]  = '{"br_over_lu", 5'd8,  5'd0,  1'b0, 1'b1, 5'd8,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, O_TAKEN};
        vecs[7]  = '{"br_not_tkn", 5'd8,  5'd0,  1'b0, 1'b1, 5'd8,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_LU};
        vecs[8]  = '{"jump",       5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, O_TAKEN};
        vecs[9]  = '{"zero_only",  5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, O_NONE};
        vecs[10] = '{"zw_lu",      5'd8,  5'd0,  1'b0, 1'b1, 5'd8,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, O_LU};
        vecs[11] = '{"zw_jump",    5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, O_TAKEN};
        vecs[12] = '{"lu_r31",     5'd31, 5'd0,  1'b0, 1'b1, 5'd31, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_LU};
        vecs[13] = '{"lu_miss",    5'd9,  5'd7,  1'b1, 1'b1, 5'd8,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE};

        // Saturation instance stays idle until its own phase.
        bus2.id_rs = 5'd0; bus2.id_rt = 5'd0; bus2.id_uses_rt = 1'b0;
        bus2.ex_MemRead = 1'b0; bus2.ex_rt = 5'd0; bus2.mem_Branch = 1'b0;
        bus2.mem_Zero = 1'b0; bus2.mem_Jump = 1'b0; bus2.mem_req = 1'b0;
        bus2.mem_ready = 1'b0;

        // ---- reset ----
        rst = 1'b1;
        clear_in();
        cycle("reset_out0", O_RESET);
        cycle("reset_out1", O_RESET);
        rst = 1'b0;
        #1;
        chk("reset_mem_err", {31'd0, mem_err}, 32'd0);
        chk("reset_stall_cnt", {16'd0, stall_cnt}, 32'd0);

        // ---- RUN-state decode table ----
        for (int i = 0; i < 14; i++) begin
            set_in(vecs[i]);
            cycle(vecs[i].name, vecs[i].exp);
        end
        clear_in();
        #1;
        chk("table_stall_cnt", {16'd0, stall_cnt}, exp_cnt);

        // ---- memory wait: 3 not-ready cycles then ready; branch masked ----
        bus.mem_req    = 1'b1;
        bus.mem_ready  = 1'b0;
        bus.mem_Branch = 1'b1;
        bus.mem_Zero   = 1'b1;
        cycle("mw_enter", O_MEMW);
        cycle("mw_wait1", O_MEMW);
        cycle("mw_wait2", O_MEMW);
        bus.mem_ready = 1'b1;
        cycle("mw_ready", O_MEMW);
        bus.mem_req   = 1'b0;
        bus.mem_ready = 1'b0;
        cycle("mw_branch_after", O_TAKEN);
        clear_in();
        cycle("mw_idle", O_NONE);
        chk("mw_stall_cnt", {16'd0, stall_cnt}, exp_cnt);
        chk("mw_no_err", {31'd0, mem_err}, 32'd0);

        // ---- timeout: entry cycle plus 15 MEMWAIT cycles ----
        bus.mem_req   = 1'b1;
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            #1;
            chk($sformatf("to_err_early%0d", i), {31'd0, mem_err}, 32'd0);
            cycle($sformatf("to_stall%0d", i), O_MEMW);
        end
        bus.mem_req = 1'b0;
        #1;
        chk("to_err_set", {31'd0, mem_err}, 32'd1);
        cycle("to_back_run", O_NONE);
        cycle("to_idle", O_NONE);
        chk("to_err_sticky", {31'd0, mem_err}, 32'd1);
        chk("to_stall_cnt", {16'd0, stall_cnt}, exp_cnt);

        // ---- reset in the middle of MEMWAIT ----
        bus.mem_req   = 1'b1;
        bus.mem_ready = 1'b0;
        cycle("rmw_enter", O_MEMW);
        cycle("rmw_wait", O_MEMW);
        rst = 1'b1;
        cycle("rmw_reset", O_RESET);
        rst = 1'b0;
        exp_cnt = 0;
        bus.mem_req = 1'b0;
        #1;
        chk("rmw_err_clr", {31'd0, mem_err}, 32'd0);
        chk("rmw_cnt_clr", {16'd0, stall_cnt}, 32'd0);
        cycle("rmw_run", O_NONE);

        // ---- saturation on the 4-bit counter instance ----
        chk("sat_start", {28'd0, stall_cnt2}, 32'd0);
        bus2.ex_MemRead = 1'b1;
        bus2.ex_rt      = 5'd8;
        bus2.id_rs      = 5'd8;
        #1;
        chk("sat_pc_stall", {31'd0, bus2.pc_stall}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
        #1;
        chk("sat_mid", {28'd0, stall_cnt2}, 32'd10);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
        #1;
        chk("sat_end", {28'd0, stall_cnt2}, 32'd15);
        bus2.ex_MemRead = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
